general_register_file: RTL and testbench
========================================

Name: general_register_file

Overview:
- Bank of four independent 8-bit general-purpose registers sharing one data input bus.
- Each register has its own load enable and its own always-visible output.
- Used as the small register file of the datapath; downstream logic reads the outputs combinationally.

Parameters:
- WIDTH, 8, data width of the input bus and of each register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load0  input  1  write enable for register 0.
- load1  input  1  write enable for register 1.
- load2  input  1  write enable for register 2.
- load3  input  1  write enable for register 3.
- in  input  WIDTH  shared write data.
- out0  output  WIDTH  current contents of register 0.
- out1  output  WIDTH  current contents of register 1.
- out2  output  WIDTH  current contents of register 2.
- out3  output  WIDTH  current contents of register 3.

Behaviour:
- Clocking and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset:
  - When reset=1 at a rising clk edge, all four registers become 0.
  - Reset has priority over every loadN.
  - Reset is sampled only at edges; asserting it between edges changes nothing until the next edge.
- Load:
  - At a rising edge with reset=0 and loadN=1, register N captures in.
  - The new value appears on outN immediately after that edge (one-edge write latency).
  - There is no bypass: outN never reflects in combinationally.
- Hold: at a rising edge with reset=0 and loadN=0, register N keeps its value indefinitely.
- Simultaneous loads:
  - Any combination of load0..load3 may be high in the same cycle.
  - Every enabled register captures the same in value; disabled ones hold.
  - No priority or encoding among the loads.
- Outputs:
  - out0..out3 are driven directly from register state: glitch-free and stable for the whole cycle.
  - They are independent of in and the load inputs between edges.
- Power-up: register contents are undefined until the first reset edge. Verification must apply reset before checking values.
- Inputs loadN and in must be stable around the rising edge (normal setup/hold). Values that change only after the edge take effect at the following edge.
- No handshake and no error conditions. Width is fixed at WIDTH; no arithmetic, truncation or extension.

Decomposition:
- Shared package:
  - WIDTH default (8).
  - NUM_REGS constant (4).
  - A data-word typedef of WIDTH bits.
- One sub-module, gp_reg_cell: a single WIDTH-bit register with clk, synchronous reset, load enable, data in and data out.
  - The top level instantiates it four times.
  - Each instance connects one loadN/outN pair to the shared in bus.

Test Plan:
- Reset: preload all registers with nonzero values, assert reset for one edge with all loads high and in=8'hFF. Then out0..out3=0.
- Sequential single loads, each followed by an edge with all loads low and in=0:
  - load0=1, in=3 at an edge: out0=3.
  - load1=1, in=5: out1=5.
  - load2=1, in=6: out2=6.
  - load3=1, in=9: out3=9.
  - Final state: out0=3, out1=5, out2=6, out3=9, with earlier values held throughout.
- Hold: five edges with all loads low and in toggling 0/8'hAA. All outputs unchanged (3/5/6/9).
- Simultaneous load: load0..load3=1, in=8'h5A for one edge. All outputs=8'h5A. Next edge with loads low: all remain 8'h5A.
- Reset mid-operation: reset=1 together with load2=1, in=8'h77. All outputs=0, including out2. Next edge with reset=0, load2=1, in=8'h77: out2=8'h77, others 0.
- Between-edge stability: change in and load1 mid-cycle with no edge. out1 does not change until the next rising edge, then equals the value present at that edge.

Source files
------------

// File: rtl/general_register_file_pkg.sv
// Shared constants and types for the four-entry general register file.
package general_register_file_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int NUM_REGS      = 4;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/general_register_file_gp_reg_cell.sv
// One loadable register with synchronous clear; a load appears on o_q one edge later.
// There is no bypass, so o_q changes only at clock edges.
module gp_reg_cell
  import general_register_file_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear wins over load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/general_register_file.sv
// Four independent registers share one write bus; each has its own load and output.
// Write latency is one edge, reads are direct from state, and there is no handshake.
module general_register_file
  import general_register_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load0,
  input  logic             load1,
  input  logic             load2,
  input  logic             load3,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3
);

  logic [NUM_REGS-1:0] w_load;
  logic [WIDTH-1:0]    w_out [NUM_REGS];

  assign w_load = {load3, load2, load1, load0};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    gp_reg_cell #(
      .W(WIDTH)
    ) u_cell (
      .i_clk  (clk),
      .i_reset(reset),
      .i_load (w_load[g]),
      .i_d    (in),
      .o_q    (w_out[g])
    );
  end

  assign out0 = w_out[0];
  assign out1 = w_out[1];
  assign out2 = w_out[2];
  assign out3 = w_out[3];

endmodule

// File: tb/tb_general_register_file.sv
// Randomized and directed stimulus against an array model of the register file;
// expected register contents are queued per edge and checked by a separate monitor.
module tb_general_register_file;
  import general_register_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load0 = 1'b0, load1 = 1'b0, load2 = 1'b0, load3 = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  out0, out1, out2, out3;

  int checks = 0;
  int errors = 0;

  word_t       mdl [4];
  bit          mdl_known = 1'b0;
  logic [31:0] exp_q [$];

  general_register_file #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .load0(load0),
    .load1(load1),
    .load2(load2),
    .load3(load3),
    .in   (din),
    .out0 (out0),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  always #5 clk = ~clk;

  // Reference behaviour at a rising edge, from the values the bench is driving.
  task automatic apply_edge();
    logic [3:0] ld;
    ld = {load3, load2, load1, load0};
    if (reset) begin
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      mdl_known = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (ld[i]) mdl[i] = din;
    end
    if (mdl_known) exp_q.push_back({mdl[3], mdl[2], mdl[1], mdl[0]});
  endtask

  task automatic step(input bit rst, input logic [3:0] ld, input logic [7:0] d);
    @(negedge clk);
    reset = rst;
    {load3, load2, load1, load0} = ld;
    din = d;
    @(posedge clk);
    apply_edge();
  endtask

  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per edge, sampled just after the edge.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_now("out0", out0, e[7:0]);
      check_now("out1", out1, e[15:8]);
      check_now("out2", out2, e[23:16]);
      check_now("out3", out3, e[31:24]);
    end
  end

  initial begin
    // Establish known state, then preload nonzero values.
    step(1'b1, 4'b0000, 8'h00);
    step(1'b0, 4'b0001, 8'h11);
    step(1'b0, 4'b0010, 8'h22);
    step(1'b0, 4'b0100, 8'h33);
    step(1'b0, 4'b1000, 8'h44);
    // Reset overrides all loads.
    step(1'b1, 4'b1111, 8'hFF);
    // Sequential single loads with idle edges between.
    step(1'b0, 4'b0001, 8'd3); step(1'b0, 4'b0000, 8'd0);
    step(1'b0, 4'b0010, 8'd5); step(1'b0, 4'b0000, 8'd0);
    step(1'b0, 4'b0100, 8'd6); step(1'b0, 4'b0000, 8'd0);
    step(1'b0, 4'b1000, 8'd9); step(1'b0, 4'b0000, 8'd0);
    // Hold while the data bus toggles.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, (i % 2) ? 8'hAA : 8'h00);
    // Simultaneous load, then hold.
    step(1'b0, 4'b1111, 8'h5A);
    step(1'b0, 4'b0000, 8'h00);
    // Reset together with a load, then the load alone.
    step(1'b1, 4'b0100, 8'h77);
    step(1'b0, 4'b0100, 8'h77);

    // Inputs change between edges: outputs must not follow until the edge.
    @(negedge clk);
    reset = 1'b0;
    {load3, load2, load1, load0} = 4'b0000;
    din = 8'h11;
    #2;
    din = 8'h3C;
    load1 = 1'b1;
    #1;
    check_now("midcycle_out1", out1, mdl[1]);
    check_now("midcycle_out2", out2, mdl[2]);
    @(posedge clk);
    apply_edge();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15) == 0), 4'($urandom_range(15)), 8'($urandom_range(255)));
    end
    step(1'b0, 4'b0000, 8'h00);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
